// File: rtl/btn_arb_pkg.sv
// Shared types and helpers for the 4-button round-robin / fixed-priority arbiter.
// Used by rr_pick and btn_rr_arbiter.
package btn_arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot_from_idx(input logic [1:0] idx);
        onehot_from_idx = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: round-robin from ptr, or fixed order from 0.
// valid is low when no request is pending.
module rr_pick
    import btn_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    input  logic             fixed,
    output logic             valid,
    output logic [1:0]       idx
);

    logic [1:0] start;

    assign start = fixed ? 2'd0 : ptr;

    // Scan four slots starting at start, wrapping mod 4; first hit wins
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [1:0] k;
            k = start + 2'(i);
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/btn_rr_arbiter.sv
// 4-button / 4-LED grant controller with min/max hold and one-cycle dead time.
// Optional macro BTN_SYNC_EN adds a 2-flop synchronizer on btn.
module btn_rr_arbiter
    import btn_arb_pkg::*;
#(
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] btn,
    input  logic [1:0]       sw,
    output logic [N_REQ-1:0] led,
    output logic [1:0]       sel,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);

    logic [N_REQ-1:0] req;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [N_REQ-1:0] led_q, led_d;
    logic             pick_valid;
    logic [1:0]       pick_idx;

`ifdef BTN_SYNC_EN
    logic [N_REQ-1:0] sync1_q, sync2_q;

    // Two-stage synchronizer for the asynchronous button lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign req = sync2_q;
`else
    assign req = btn;
`endif

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .fixed (sw[0]),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state: arbitrate in IDLE, time the grant, one dead cycle in GAP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid && !sw[1]) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if ((cnt_q >= MIN_C && !req[sel_q]) || cnt_q == MAX_C) begin
                    state_d = ST_GAP;
                    ptr_d   = sel_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q != MAX_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        led_d = (state_d == ST_GRANT) ? onehot_from_idx(sel_d) : '0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign sel  = sel_q;
    assign busy = (state_q == ST_GRANT);

endmodule
